// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, exception codes, status/cause bit positions, selpc encodings.
package cp0_pkg;

    localparam int unsigned CP0_DW = 32;

    // CP0 register indices
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Cause.exccode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_UNI = 5'd10;
    localparam logic [4:0] EXC_OVR = 5'd12;

    // Status bit positions; IEo owns bit 4, so the sync-exception enables sit at bits 5..7
    localparam int unsigned ST_IEC    = 0;
    localparam int unsigned ST_IEP    = 2;
    localparam int unsigned ST_IEO    = 4;
    localparam int unsigned ST_EN_SYS = 5;
    localparam int unsigned ST_EN_UNI = 6;
    localparam int unsigned ST_EN_OVR = 7;
    localparam int unsigned ST_IM_LSB = 8;

    // Cause bit positions
    localparam int unsigned CA_CODE_LSB = 2;
    localparam int unsigned CA_CODE_W   = 5;
    localparam int unsigned CA_IP_LSB   = 8;

    // selpc encodings
    localparam logic [1:0] SELPC_NPC = 2'b00;
    localparam logic [1:0] SELPC_EPC = 2'b01;
    localparam logic [1:0] SELPC_EXC = 2'b10;

    // Exception code of the highest-priority sync exception (ovr > uni > sys), else interrupt
    function automatic logic [4:0] exc_code(input logic ovr, input logic uni, input logic sys);
        logic [4:0] code;
        code = EXC_INT;
        if (ovr) begin
            code = EXC_OVR;
        end else if (uni) begin
            code = EXC_UNI;
        end else if (sys) begin
            code = EXC_SYS;
        end
        return code;
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// cp0_prio_enc: lowest-index-first one-hot priority encoder with valid flag.
module cp0_prio_enc
    import cp0_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt,
    output logic         o_valid
);

    // Isolate the lowest set bit: req AND its two's complement
    assign o_gnt   = i_req & (~i_req + N'(1));
    assign o_valid = |i_req;

endmodule

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 status/cause/EPC with interrupt and sync-exception arbitration.
// Build option: define CP0_NEST_EN for a three-deep IE stack (IEo); otherwise two-deep.
module cp0_intr_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned NIRQ     = 4,
    parameter logic [31:0] EXC_BASE = 32'h0000_0008
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [NIRQ-1:0] irq,
    input  logic            exc_sys,
    input  logic            exc_uni,
    input  logic            exc_ovr,
    input  logic [31:0]     pc,
    input  logic            i_mtc0,
    input  logic            i_mfc0,
    input  logic            i_eret,
    input  logic [4:0]      rd,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            exc,
    output logic [NIRQ-1:0] inta,
    output logic [1:0]      selpc,
    output logic [31:0]     newpc
);

    logic [NIRQ-1:0]   r_irq_q, r_ip, r_im;
    logic              r_ie_c, r_ie_p, r_ie_o;
    logic [2:0]        r_en;
    logic [4:0]        r_code;
    logic [CP0_DW-1:0] r_epc;

    logic [NIRQ-1:0]   w_ip_n, w_im_n;
    logic              w_ie_c_n, w_ie_p_n, w_ie_o_n;
    logic [2:0]        w_en_n;
    logic [4:0]        w_code_n;
    logic [CP0_DW-1:0] w_epc_n;

    logic [NIRQ-1:0]   w_rise, w_pend, w_gnt, w_ack;
    logic              w_pend_v, w_ovr, w_uni, w_sys, w_int_win, w_exc, w_eret;
    logic [4:0]        w_code;
    logic [CP0_DW-1:0] w_status, w_cause;
    logic              w_unused_wdata;

    assign w_rise         = irq & ~r_irq_q;
    assign w_pend         = r_ip & r_im;
    assign w_unused_wdata = ^wdata;

    cp0_prio_enc #(.N(NIRQ)) u_prio_enc (
        .i_req   (w_pend),
        .o_gnt   (w_gnt),
        .o_valid (w_pend_v)
    );

    // Arbitration: enabled sync exceptions (ovr > uni > sys) beat an eligible interrupt
    always_comb begin
        w_ovr     = exc_ovr & r_en[2];
        w_uni     = exc_uni & r_en[1];
        w_sys     = exc_sys & r_en[0];
        w_int_win = r_ie_c & w_pend_v & ~(w_ovr | w_uni | w_sys);
        w_exc     = w_ovr | w_uni | w_sys | w_int_win;
        w_code    = exc_code(w_ovr, w_uni, w_sys);
        w_ack     = w_int_win ? w_gnt : '0;
        w_eret    = i_eret & ~w_exc;
    end

    // Redirect outputs, held at zero while clrn is low
    always_comb begin
        exc   = clrn & w_exc;
        inta  = clrn ? w_ack : '0;
        selpc = SELPC_NPC;
        newpc = '0;
        if (clrn) begin
            if (w_exc) begin
                selpc = SELPC_EXC;
            end else if (w_eret) begin
                selpc = SELPC_EPC;
            end
            newpc = w_exc ? EXC_BASE : r_epc;
        end
    end

    // Register readback from current (pre-edge) state
    always_comb begin
        w_status                           = '0;
        w_status[ST_IEC]                   = r_ie_c;
        w_status[ST_IEP]                   = r_ie_p;
        w_status[ST_IEO]                   = r_ie_o;
        w_status[ST_EN_SYS]                = r_en[0];
        w_status[ST_EN_UNI]                = r_en[1];
        w_status[ST_EN_OVR]                = r_en[2];
        w_status[ST_IM_LSB +: NIRQ]        = r_im;
        w_cause                            = '0;
        w_cause[CA_CODE_LSB +: CA_CODE_W]  = r_code;
        w_cause[CA_IP_LSB +: NIRQ]         = r_ip;
        rdata                              = '0;
        if (i_mfc0) begin
            case (rd)
                CP0_REG_STATUS: rdata = w_status;
                CP0_REG_CAUSE:  rdata = w_cause;
                CP0_REG_EPC:    rdata = r_epc;
                default:        rdata = '0;
            endcase
        end
    end

    // Next state: exception entry beats eret/mtc0; a new irq rise always wins over an ack
    always_comb begin
        w_ip_n   = r_ip;
        w_im_n   = r_im;
        w_ie_c_n = r_ie_c;
        w_ie_p_n = r_ie_p;
        w_ie_o_n = r_ie_o;
        w_en_n   = r_en;
        w_code_n = r_code;
        w_epc_n  = r_epc;
        if (w_exc) begin
            w_epc_n  = pc;
            w_code_n = w_code;
            w_ip_n   = r_ip & ~w_ack;
`ifdef CP0_NEST_EN
            w_ie_o_n = r_ie_p;
`endif
            w_ie_p_n = r_ie_c;
            w_ie_c_n = 1'b0;
        end else begin
            if (i_mtc0) begin
                case (rd)
                    CP0_REG_STATUS: begin
                        w_ie_c_n = wdata[ST_IEC];
                        w_ie_p_n = wdata[ST_IEP];
`ifdef CP0_NEST_EN
                        w_ie_o_n = wdata[ST_IEO];
`endif
                        w_en_n   = {wdata[ST_EN_OVR], wdata[ST_EN_UNI], wdata[ST_EN_SYS]};
                        w_im_n   = wdata[ST_IM_LSB +: NIRQ];
                    end
                    CP0_REG_CAUSE: w_ip_n  = wdata[CA_IP_LSB +: NIRQ];
                    CP0_REG_EPC:   w_epc_n = wdata;
                    default: ;
                endcase
            end
            if (w_eret) begin
`ifdef CP0_NEST_EN
                w_ie_p_n = r_ie_o;
`endif
                w_ie_c_n = r_ie_p;
            end
        end
        w_ip_n = w_ip_n | w_rise;
    end

    // State registers, cleared asynchronously by clrn
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_irq_q <= '0;
            r_ip    <= '0;
            r_im    <= '0;
            r_ie_c  <= 1'b0;
            r_ie_p  <= 1'b0;
            r_ie_o  <= 1'b0;
            r_en    <= '0;
            r_code  <= '0;
            r_epc   <= '0;
        end else begin
            r_irq_q <= irq;
            r_ip    <= w_ip_n;
            r_im    <= w_im_n;
            r_ie_c  <= w_ie_c_n;
            r_ie_p  <= w_ie_p_n;
            r_ie_o  <= w_ie_o_n;
            r_en    <= w_en_n;
            r_code  <= w_code_n;
            r_epc   <= w_epc_n;
        end
    end

endmodule
